// File: rtl/apb_protocol_monitor.sv
// Passive APB protocol monitor: follows IDLE/SETUP/ACCESS on a shared APB
// segment, latches protocol violations as sticky bits, counts completions.
//
// Ports
//   pclk, presetn      clock, async active-low reset
//   psel..pslverr      observed APB bus (never driven)
//   err_clr            clears err_sticky and last_err_addr
//   cnt_clr            clears wr_cnt, rd_cnt, slverr_cnt
//   err_mask           per-bit interrupt enable for err_sticky
//   err_sticky         [0]MULTI_SEL [1]SETUP_SKIP [2]ENABLE_LATE [3]UNSTABLE
//                      [4]TIMEOUT [5]ABORT [6]PENABLE_STUCK
//   err_pulse          one-cycle pulse on any new detection
//   irq                registered |(err_sticky & err_mask)
//   last_err_addr      address associated with the latest detection
//   wr_cnt/rd_cnt      completed writes/reads (saturating)
//   slverr_cnt         completions with pslverr (saturating)
//   mon_state          00 IDLE, 01 SETUP, 10 ACCESS
module apb_protocol_monitor #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int NUM_SLV = 4,
   parameter int TIMEOUT = 16,
   parameter int CNT_W   = 16
) (
   input  logic              pclk,
   input  logic              presetn,
   input  logic [NUM_SLV-1:0] psel,
   input  logic              penable,
   input  logic              pwrite,
   input  logic [ADDR_W-1:0] paddr,
   input  logic [DATA_W-1:0] pwdata,
   input  logic              pready,
   input  logic              pslverr,
   input  logic              err_clr,
   input  logic              cnt_clr,
   input  logic [6:0]        err_mask,
   output logic [6:0]        err_sticky,
   output logic              err_pulse,
   output logic              irq,
   output logic [ADDR_W-1:0] last_err_addr,
   output logic [CNT_W-1:0]  wr_cnt,
   output logic [CNT_W-1:0]  rd_cnt,
   output logic [CNT_W-1:0]  slverr_cnt,
   output logic [1:0]        mon_state
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'b00,
      S_SETUP  = 2'b01,
      S_ACCESS = 2'b10
   } state_t;

   localparam int WAIT_W =
      (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [WAIT_W-1:0] TO_V = WAIT_W'(TIMEOUT);
   localparam bit TO_EN = (TIMEOUT > 0);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   localparam int E_MULTI = 0;
   localparam int E_SKIP  = 1;
   localparam int E_LATE  = 2;
   localparam int E_UNST  = 3;
   localparam int E_TOUT  = 4;
   localparam int E_ABORT = 5;
   localparam int E_STUCK = 6;

   state_t              state_q;
   state_t              state_d;

   logic [NUM_SLV-1:0]  cap_sel_q;
   logic [ADDR_W-1:0]   cap_addr_q;
   logic                cap_write_q;
   logic [DATA_W-1:0]   cap_wdata_q;

   logic                done_q;
   logic                unst_q;
   logic                unst_d;
   logic [WAIT_W-1:0]   wait_q;
   logic [WAIT_W-1:0]   wait_d;

   logic                sel_any;
   logic                multi_sel;
   logic                mismatch;
   logic                capture;
   logic                complete;
   logic [6:0]          det;
   logic [ADDR_W-1:0]   err_addr;

   assign sel_any   = |psel;
   // Clearing the lowest set bit leaves something only if >1 bit was set.
   assign multi_sel = |(psel & (psel - 1'b1));

   assign mismatch = (psel != cap_sel_q)
                   || (paddr != cap_addr_q)
                   || (pwrite != cap_write_q)
                   || (cap_write_q && (pwdata != cap_wdata_q));

   // In IDLE nothing has been captured yet, so report the live address.
   assign err_addr = (state_q == S_IDLE) ? paddr : cap_addr_q;

   assign mon_state = state_q;

   always_ff @(posedge pclk or negedge presetn) begin
      if (!presetn) begin
         state_q <= S_IDLE;
         wait_q  <= '0;
         unst_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         wait_q  <= wait_d;
         unst_q  <= unst_d;
         done_q  <= complete;
      end
   end

   always_comb begin
      state_d  = state_q;
      wait_d   = wait_q;
      unst_d   = unst_q;
      capture  = 1'b0;
      complete = 1'b0;
      det      = '0;

      det[E_MULTI] = multi_sel;

      unique case (state_q)
         S_IDLE: begin
            if (penable) begin
               if (done_q) begin
                  det[E_STUCK] = 1'b1;
               end else begin
                  det[E_SKIP] = 1'b1;
               end
            end else if (sel_any) begin
               state_d = S_SETUP;
               capture = 1'b1;
               unst_d  = 1'b0;
            end
         end

         S_SETUP: begin
            if (mismatch && !unst_q) begin
               det[E_UNST] = 1'b1;
               unst_d      = 1'b1;
            end
            if (!penable) begin
               det[E_LATE] = 1'b1;
               if (sel_any) begin
                  capture = 1'b1;
               end else begin
                  state_d = S_IDLE;
               end
            end else if (pready) begin
               complete = 1'b1;
               state_d  = S_IDLE;
            end else begin
               state_d = S_ACCESS;
               wait_d  = WAIT_W'(1);
               if (TO_EN && (TO_V == WAIT_W'(1))) begin
                  det[E_TOUT] = 1'b1;
               end
            end
         end

         S_ACCESS: begin
            if (mismatch && !unst_q) begin
               det[E_UNST] = 1'b1;
               unst_d      = 1'b1;
            end
            if (!penable || !sel_any) begin
               det[E_ABORT] = 1'b1;
               state_d      = S_IDLE;
            end else if (pready) begin
               complete = 1'b1;
               state_d  = S_IDLE;
            end else if (TO_EN && (wait_q != TO_V)) begin
               // Counter parks at the limit, so the flag fires once.
               wait_d = wait_q + 1'b1;
               if (wait_d == TO_V) begin
                  det[E_TOUT] = 1'b1;
               end
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge pclk or negedge presetn) begin
      if (!presetn) begin
         cap_sel_q   <= '0;
         cap_addr_q  <= '0;
         cap_write_q <= 1'b0;
         cap_wdata_q <= '0;
      end else if (capture) begin
         cap_sel_q   <= psel;
         cap_addr_q  <= paddr;
         cap_write_q <= pwrite;
         if (pwrite) begin
            cap_wdata_q <= pwdata;
         end
      end
   end

   always_ff @(posedge pclk or negedge presetn) begin
      if (!presetn) begin
         err_sticky    <= '0;
         err_pulse     <= 1'b0;
         irq           <= 1'b0;
         last_err_addr <= '0;
      end else begin
         // A detection coinciding with err_clr survives the clear.
         err_sticky <= err_clr ? det : (err_sticky | det);
         err_pulse  <= |det;
         irq        <= |(err_sticky & err_mask);
         if (|det) begin
            last_err_addr <= err_addr;
         end else if (err_clr) begin
            last_err_addr <= '0;
         end
      end
   end

   always_ff @(posedge pclk or negedge presetn) begin
      if (!presetn) begin
         wr_cnt     <= '0;
         rd_cnt     <= '0;
         slverr_cnt <= '0;
      end else if (cnt_clr) begin
         wr_cnt     <= '0;
         rd_cnt     <= '0;
         slverr_cnt <= '0;
      end else if (complete) begin
         if (pwrite && (wr_cnt != CNT_MAX)) begin
            wr_cnt <= wr_cnt + 1'b1;
         end
         if (!pwrite && (rd_cnt != CNT_MAX)) begin
            rd_cnt <= rd_cnt + 1'b1;
         end
         if (pslverr && (slverr_cnt != CNT_MAX)) begin
            slverr_cnt <= slverr_cnt + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_apb_protocol_monitor.sv
// Bench for apb_protocol_monitor: vector table, directed corner sequences
// and randomized traffic checked against a transfer-level reference model.
module tb_apb_protocol_monitor;

   localparam int AW = 32;
   localparam int DW = 32;
   localparam int NS = 4;
   localparam int TO = 16;
   localparam int CW = 16;

   logic          pclk = 1'b0;
   logic          presetn = 1'b1;
   logic [NS-1:0] psel;
   logic          penable;
   logic          pwrite;
   logic [AW-1:0] paddr;
   logic [DW-1:0] pwdata;
   logic          pready;
   logic          pslverr;
   logic          err_clr;
   logic          cnt_clr;
   logic [6:0]    err_mask;
   logic [6:0]    err_sticky;
   logic          err_pulse;
   logic          irq;
   logic [AW-1:0] last_err_addr;
   logic [CW-1:0] wr_cnt;
   logic [CW-1:0] rd_cnt;
   logic [CW-1:0] slverr_cnt;
   logic [1:0]    mon_state;

   apb_protocol_monitor #(
      .ADDR_W(AW), .DATA_W(DW), .NUM_SLV(NS),
      .TIMEOUT(TO), .CNT_W(CW)
   ) dut (
      .pclk(pclk), .presetn(presetn),
      .psel(psel), .penable(penable), .pwrite(pwrite),
      .paddr(paddr), .pwdata(pwdata),
      .pready(pready), .pslverr(pslverr),
      .err_clr(err_clr), .cnt_clr(cnt_clr), .err_mask(err_mask),
      .err_sticky(err_sticky), .err_pulse(err_pulse), .irq(irq),
      .last_err_addr(last_err_addr),
      .wr_cnt(wr_cnt), .rd_cnt(rd_cnt), .slverr_cnt(slverr_cnt),
      .mon_state(mon_state)
   );

   always #5 pclk = ~pclk;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // ---------------- reference model ----------------
   typedef struct {
      logic [NS-1:0] sel;
      logic [AW-1:0] addr;
      logic          wr;
      logic [DW-1:0] wd;
   } xfer_t;

   int          m_ph;      // 0 idle, 1 setup, 2 access
   xfer_t       m_x;
   bit          m_done;
   bit          m_unst;
   int          m_waits;   // penable&!pready samples in this transfer
   logic [6:0]  m_sticky;
   logic        m_pulse;
   logic        m_irq;
   logic [AW-1:0] m_lea;
   int          m_wr, m_rd, m_se;

   function automatic int sat_inc(input int v);
      return (v >= (1 << CW) - 1) ? v : v + 1;
   endfunction

   task automatic model_reset();
      m_ph = 0; m_x = '{default: '0}; m_done = 0; m_unst = 0;
      m_waits = 0; m_sticky = '0; m_pulse = 0; m_irq = 0;
      m_lea = '0; m_wr = 0; m_rd = 0; m_se = 0;
   endtask

   task automatic model_step();
      logic [6:0] d = '0;
      bit comp = 0;
      bit sel_any = (psel != '0);
      bit differs;
      logic [AW-1:0] ea;
      xfer_t now;
      now = '{psel, paddr, pwrite, pwdata};
      d[0] = ($countones(psel) > 1);
      ea = (m_ph == 0) ? paddr : m_x.addr;
      differs = (psel != m_x.sel) || (paddr != m_x.addr)
             || (pwrite != m_x.wr) || (m_x.wr && pwdata != m_x.wd);
      if (m_ph != 0 && differs && !m_unst) begin
         d[3] = 1; m_unst = 1;
      end
      if (m_ph == 0) begin
         if (penable) begin
            if (m_done) d[6] = 1; else d[1] = 1;
         end else if (sel_any) begin
            m_ph = 1; m_x = now; m_unst = 0;
         end
      end else if (m_ph == 1) begin
         if (!penable) begin
            d[2] = 1;
            if (sel_any) m_x = now; else m_ph = 0;
         end else if (pready) begin
            comp = 1; m_ph = 0;
         end else begin
            m_ph = 2; m_waits = 1;
            if (m_waits == TO) d[4] = 1;
         end
      end else begin
         if (!penable || !sel_any) begin
            d[5] = 1; m_ph = 0;
         end else if (pready) begin
            comp = 1; m_ph = 0;
         end else begin
            m_waits++;
            if (m_waits == TO) d[4] = 1;
         end
      end
      m_done = comp;
      m_irq = |(m_sticky & err_mask);
      m_sticky = err_clr ? d : (m_sticky | d);
      m_pulse = |d;
      if (|d) m_lea = ea;
      else if (err_clr) m_lea = '0;
      if (cnt_clr) begin
         m_wr = 0; m_rd = 0; m_se = 0;
      end else if (comp) begin
         if (pwrite) m_wr = sat_inc(m_wr); else m_rd = sat_inc(m_rd);
         if (pslverr) m_se = sat_inc(m_se);
      end
   endtask

   // ---------------- drivers ----------------
   task automatic step();
      @(posedge pclk);
      model_step();
      #1;
      chk("state", 64'(mon_state), 64'(m_ph));
      chk("sticky", 64'(err_sticky), 64'(m_sticky));
      chk("pulse", 64'(err_pulse), 64'(m_pulse));
      chk("irq", 64'(irq), 64'(m_irq));
      chk("lea", 64'(last_err_addr), 64'(m_lea));
      chk("wr_cnt", 64'(wr_cnt), 64'(m_wr));
      chk("rd_cnt", 64'(rd_cnt), 64'(m_rd));
      chk("se_cnt", 64'(slverr_cnt), 64'(m_se));
   endtask

   task automatic bus(input logic [NS-1:0] s, input logic en,
                      input logic wr, input logic [AW-1:0] a,
                      input logic [DW-1:0] wd, input logic rdy,
                      input logic se);
      psel = s; penable = en; pwrite = wr; paddr = a;
      pwdata = wd; pready = rdy; pslverr = se;
      step();
   endtask

   task automatic idle();
      bus('0, 0, 0, '0, '0, 0, 0);
   endtask

   task automatic do_reset();
      psel = '0; penable = 0; pwrite = 0; paddr = '0;
      pwdata = '0; pready = 0; pslverr = 0;
      err_clr = 0; cnt_clr = 0;
      #2 presetn = 0;
      #1;
      chk("rst_sticky", 64'(err_sticky), 64'd0);
      chk("rst_pulse", 64'(err_pulse), 64'd0);
      chk("rst_irq", 64'(irq), 64'd0);
      chk("rst_lea", 64'(last_err_addr), 64'd0);
      chk("rst_cnt", 64'({wr_cnt, rd_cnt, slverr_cnt}), 64'd0);
      chk("rst_state", 64'(mon_state), 64'd0);
      model_reset();
      @(posedge pclk);
      #2 presetn = 1;
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      logic [NS-1:0] sel;
      logic          en;
      logic          wr;
      logic [AW-1:0] a;
      logic          rdy;
      logic [1:0]    st;
      logic [6:0]    stk;
      logic          pl;
   } vec_t;

   vec_t tbl[20];

   task automatic run_table();
      tbl[0]  = '{4'h1, 1'b0, 1'b1, 32'h10, 1'b0, 2'd1, 7'h00, 1'b0};
      tbl[1]  = '{4'h1, 1'b1, 1'b1, 32'h10, 1'b1, 2'd0, 7'h00, 1'b0};
      tbl[2]  = '{4'h0, 1'b0, 1'b0, 32'h10, 1'b0, 2'd0, 7'h00, 1'b0};
      tbl[3]  = '{4'h1, 1'b0, 1'b0, 32'h14, 1'b0, 2'd1, 7'h00, 1'b0};
      tbl[4]  = '{4'h1, 1'b1, 1'b0, 32'h14, 1'b0, 2'd2, 7'h00, 1'b0};
      tbl[5]  = '{4'h1, 1'b1, 1'b0, 32'h14, 1'b0, 2'd2, 7'h00, 1'b0};
      tbl[6]  = '{4'h1, 1'b1, 1'b0, 32'h14, 1'b0, 2'd2, 7'h00, 1'b0};
      tbl[7]  = '{4'h1, 1'b1, 1'b0, 32'h14, 1'b1, 2'd0, 7'h00, 1'b0};
      tbl[8]  = '{4'h0, 1'b0, 1'b0, 32'h00, 1'b0, 2'd0, 7'h00, 1'b0};
      tbl[9]  = '{4'h1, 1'b0, 1'b0, 32'h18, 1'b0, 2'd1, 7'h00, 1'b0};
      tbl[10] = '{4'h1, 1'b0, 1'b0, 32'h18, 1'b0, 2'd1, 7'h04, 1'b1};
      tbl[11] = '{4'h1, 1'b1, 1'b0, 32'h18, 1'b1, 2'd0, 7'h04, 1'b0};
      tbl[12] = '{4'h0, 1'b0, 1'b0, 32'h00, 1'b0, 2'd0, 7'h04, 1'b0};
      tbl[13] = '{4'h0, 1'b1, 1'b0, 32'h00, 1'b0, 2'd0, 7'h06, 1'b1};
      tbl[14] = '{4'h1, 1'b0, 1'b0, 32'h1C, 1'b0, 2'd1, 7'h06, 1'b0};
      tbl[15] = '{4'h1, 1'b1, 1'b0, 32'h1C, 1'b0, 2'd2, 7'h06, 1'b0};
      tbl[16] = '{4'h1, 1'b0, 1'b0, 32'h1C, 1'b0, 2'd0, 7'h26, 1'b1};
      tbl[17] = '{4'h3, 1'b0, 1'b0, 32'h20, 1'b0, 2'd1, 7'h27, 1'b1};
      tbl[18] = '{4'h3, 1'b1, 1'b0, 32'h20, 1'b1, 2'd0, 7'h27, 1'b1};
      tbl[19] = '{4'h0, 1'b1, 1'b0, 32'h00, 1'b0, 2'd0, 7'h67, 1'b1};
      for (int i = 0; i < 20; i++) begin
         bus(tbl[i].sel, tbl[i].en, tbl[i].wr, tbl[i].a,
             32'hAA, tbl[i].rdy, 1'b0);
         chk($sformatf("tbl%0d_state", i), 64'(mon_state), 64'(tbl[i].st));
         chk($sformatf("tbl%0d_sticky", i), 64'(err_sticky), 64'(tbl[i].stk));
         chk($sformatf("tbl%0d_pulse", i), 64'(err_pulse), 64'(tbl[i].pl));
      end
      chk("tbl_wr_cnt", 64'(wr_cnt), 64'd1);
      chk("tbl_rd_cnt", 64'(rd_cnt), 64'd3);
   endtask

   // ---------------- randomized traffic ----------------
   task automatic rbus(input logic [NS-1:0] s, input logic en,
                       input logic wr, input logic [AW-1:0] a,
                       input logic [DW-1:0] wd, input logic rdy,
                       input logic se);
      if ($urandom_range(0, 11) == 0) begin
         case ($urandom_range(0, 3))
            0: a = a ^ (32'(1) << $urandom_range(0, 7));
            1: en = ~en;
            2: s = s | (4'b1 << $urandom_range(0, 3));
            default: s = '0;
         endcase
      end
      err_clr = ($urandom_range(0, 19) == 0);
      cnt_clr = ($urandom_range(0, 39) == 0);
      err_mask = 7'($urandom);
      bus(s, en, wr, a, wd, rdy, se);
   endtask

   task automatic run_random();
      logic [NS-1:0] s;
      logic [AW-1:0] a;
      logic [DW-1:0] wd;
      logic wr;
      int waits;
      for (int t = 0; t < 60; t++) begin
         s = 4'b1 << $urandom_range(0, 3);
         a = 32'($urandom_range(0, 15)) << 2;
         wr = 1'($urandom_range(0, 1));
         wd = $urandom;
         waits = $urandom_range(0, 20);
         repeat ($urandom_range(0, 2)) rbus('0, 0, wr, a, wd, 0, 0);
         rbus(s, 0, wr, a, wd, 0, 0);
         for (int w = 0; w < waits; w++) rbus(s, 1, wr, a, wd, 0, 0);
         rbus(s, 1, wr, a, wd, 1, 1'($urandom_range(0, 1)));
      end
      err_clr = 0;
      cnt_clr = 0;
   endtask

   // ---------------- main ----------------
   initial begin
      int pulses;
      psel = '0; penable = 0; pwrite = 0; paddr = '0; pwdata = '0;
      pready = 0; pslverr = 0; err_clr = 0; cnt_clr = 0; err_mask = '0;

      do_reset();
      run_table();

      // SETUP_SKIP with interrupt enabled, then clear
      do_reset();
      err_mask = 7'h02;
      bus('0, 1, 0, '0, '0, 0, 0);
      chk("skip_sticky", 64'(err_sticky), 64'h02);
      chk("skip_pulse", 64'(err_pulse), 64'd1);
      idle();
      chk("skip_irq", 64'(irq), 64'd1);
      chk("skip_pulse_off", 64'(err_pulse), 64'd0);
      err_clr = 1;
      idle();
      err_clr = 0;
      chk("clr_sticky", 64'(err_sticky), 64'd0);
      idle();
      chk("clr_irq", 64'(irq), 64'd0);
      err_mask = '0;

      // wait-state timeout
      do_reset();
      pulses = 0;
      bus(4'h1, 0, 0, 32'h30, '0, 0, 0);
      repeat (20) begin
         bus(4'h1, 1, 0, 32'h30, '0, 0, 0);
         pulses += int'(err_pulse);
      end
      bus(4'h1, 1, 0, 32'h30, '0, 1, 0);
      pulses += int'(err_pulse);
      chk("to_pulses", 64'(pulses), 64'd1);
      chk("to_sticky", 64'(err_sticky), 64'h10);
      chk("to_rd_cnt", 64'(rd_cnt), 64'd1);

      // address instability, then multi-select
      do_reset();
      bus(4'h1, 0, 0, 32'h20, '0, 0, 0);
      bus(4'h1, 1, 0, 32'h20, '0, 0, 0);
      bus(4'h1, 1, 0, 32'h24, '0, 0, 0);
      chk("unst_sticky", 64'(err_sticky), 64'h08);
      chk("unst_lea", 64'(last_err_addr), 64'h20);
      bus(4'h1, 1, 0, 32'h20, '0, 1, 0);
      bus(4'h3, 0, 0, 32'h40, '0, 0, 0);
      chk("multi_sticky", 64'(err_sticky), 64'h09);
      bus(4'h3, 1, 0, 32'h40, '0, 1, 0);
      idle();

      // slave error completion followed by stuck penable
      do_reset();
      bus(4'h1, 0, 0, 32'h50, '0, 0, 0);
      bus(4'h1, 1, 0, 32'h50, '0, 1, 1);
      bus('0, 1, 0, '0, '0, 0, 0);
      chk("se_cnt_hand", 64'(slverr_cnt), 64'd1);
      chk("stuck_sticky", 64'(err_sticky), 64'h40);
      err_clr = 1;
      idle();
      err_clr = 0;
      pulses = 0;
      bus(4'h2, 0, 1, 32'h60, 32'h1234, 0, 0);
      pulses += int'(err_pulse);
      bus(4'h2, 1, 1, 32'h60, 32'h1234, 1, 0);
      pulses += int'(err_pulse);
      bus(4'h2, 0, 0, 32'h64, '0, 0, 0);
      pulses += int'(err_pulse);
      bus(4'h2, 1, 0, 32'h64, '0, 1, 0);
      pulses += int'(err_pulse);
      idle();
      pulses += int'(err_pulse);
      chk("b2b_pulses", 64'(pulses), 64'd0);
      chk("b2b_sticky", 64'(err_sticky), 64'd0);
      chk("b2b_wr_cnt", 64'(wr_cnt), 64'd1);
      chk("b2b_rd_cnt", 64'(rd_cnt), 64'd2);

      // reset in the middle of ACCESS
      do_reset();
      bus(4'h1, 0, 1, 32'h70, 32'h5, 0, 0);
      bus(4'h1, 1, 1, 32'h70, 32'h5, 0, 0);
      bus(4'h1, 1, 1, 32'h70, 32'h5, 0, 0);
      do_reset();
      bus(4'h1, 0, 1, 32'h74, 32'h6, 0, 0);
      bus(4'h1, 1, 1, 32'h74, 32'h6, 1, 0);
      idle();
      chk("rst_wr_cnt", 64'(wr_cnt), 64'd1);
      chk("rst_no_abort", 64'(err_sticky), 64'd0);

      do_reset();
      run_random();
      idle();

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
